lifo_stack: RTL and testbench

- Synchronous last-in-first-out stack with registered read data and full/empty status.
- Default configuration: 8 entries of 8 bits.
- Used as a small local buffer where the most recently written word must be returned first.
- Single clock domain; push and pop are level-sampled at each rising clock edge.

---
 rtl/lifo_stack.sv | 114 +++++++++++
 tb/tb_lifo_stack.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lifo_stack.sv
// Synchronous LIFO stack with a two-edge registered pop path and registered full/empty.
// Define LIFO_ERR_FLAGS_EN to add sticky overflow (ovf) and underflow (udf) outputs.
module lifo_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             wn,
    input  logic             rn,
    output logic [WIDTH-1:0] out,
    output logic             full,
    output logic             empty
`ifdef LIFO_ERR_FLAGS_EN
    ,
    output logic             ovf,
    output logic             udf
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic [WIDTH-1:0] rd_q, rd_d;
    logic             rd_v_q, rd_v_d;
    logic [WIDTH-1:0] out_q, out_d;

    logic             push_do;
    logic             pop_do;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;

`ifdef LIFO_ERR_FLAGS_EN
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
`endif

    always_comb begin
        // Pop wins over push when both are requested in the same cycle.
        push_do = wn && !rn && !full_q;
        pop_do  = rn && !empty_q;
        wr_idx  = AW'(count_q);
        rd_idx  = AW'(count_q - CW'(1));

        count_d = count_q;
        if (pop_do) begin
            count_d = count_q - CW'(1);
        end else if (push_do) begin
            count_d = count_q + CW'(1);
        end

        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);

        rd_v_d  = pop_do;
        rd_d    = pop_do ? mem_q[rd_idx] : rd_q;
        // out only moves when the stage register holds a freshly popped word.
        out_d   = rd_v_q ? rd_q : out_q;

`ifdef LIFO_ERR_FLAGS_EN
        ovf_d   = ovf_q | (wn && !rn && full_q);
        udf_d   = udf_q | (rn && empty_q);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            rd_q    <= '0;
            rd_v_q  <= 1'b0;
            out_q   <= '0;
`ifdef LIFO_ERR_FLAGS_EN
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
`endif
        end else begin
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            rd_q    <= rd_d;
            rd_v_q  <= rd_v_d;
            out_q   <= out_d;
`ifdef LIFO_ERR_FLAGS_EN
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
`endif
        end
    end

    // Storage is deliberately left untouched by reset.
    always_ff @(posedge clk) begin
        if (rst && push_do) begin
            mem_q[wr_idx] <= in;
        end
    end

    assign out   = out_q;
    assign full  = full_q;
    assign empty = empty_q;
`ifdef LIFO_ERR_FLAGS_EN
    assign ovf   = ovf_q;
    assign udf   = udf_q;
`endif

endmodule

// File: tb/tb_lifo_stack.sv
// Self-checking bench for lifo_stack: directed scenarios plus randomized traffic
// compared against a queue-based stack model.
module tb_lifo_stack;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] din;
    logic             wn;
    logic             rn;
    logic [WIDTH-1:0] dout;
    logic             full;
    logic             empty;
`ifdef LIFO_ERR_FLAGS_EN
    logic             ovf;
    logic             udf;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: stack contents, words popped but not yet on out, expected out.
    logic [WIDTH-1:0] stk[$];
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] exp_out;
    logic             exp_ovf;
    logic             exp_udf;

    lifo_stack #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .in   (din),
        .wn   (wn),
        .rn   (rn),
        .out  (dout),
        .full (full),
        .empty(empty)
`ifdef LIFO_ERR_FLAGS_EN
        ,
        .ovf  (ovf),
        .udf  (udf)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver + model ----------------
    task automatic tick(input logic w, input logic r, input logic [WIDTH-1:0] d, input logic rs);
        wn  = w;
        rn  = r;
        din = d;
        rst = rs;
        @(posedge clk);
        if (!rs) begin
            stk.delete();
            exp_q.delete();
            exp_out = '0;
            exp_ovf = 1'b0;
            exp_udf = 1'b0;
        end else begin
            if (exp_q.size() > 0) exp_out = exp_q.pop_front();
            if (r) begin
                if (stk.size() > 0) exp_q.push_back(stk.pop_back());
                else exp_udf = 1'b1;
            end else if (w) begin
                if (stk.size() < DEPTH) stk.push_back(d);
                else exp_ovf = 1'b1;
            end
        end
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        tick(1'b0, 1'b0, '0, 1'b0);
        n_tests++;
        if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_tests++;
        if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
        n_tests++;
        if (dout !== 8'd0) begin n_fail++; $display("FAIL reset_out: got %0d want 0", dout); end
        tick(1'b0, 1'b0, '0, 1'b1);
        n_tests++;
        if (empty !== 1'b1 || full !== 1'b0 || dout !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_idle: got empty=%b full=%b out=%0d want 1 0 0", empty, full, dout);
        end
    endtask

    task automatic test_lifo_order();
        logic [WIDTH-1:0] vals [7];
        logic [WIDTH-1:0] pops [7];
        vals = '{8'd100, 8'd150, 8'd200, 8'd40, 8'd70, 8'd65, 8'd15};
        pops = '{8'd15, 8'd65, 8'd70, 8'd40, 8'd200, 8'd150, 8'd100};
        tick(1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 7; i++) tick(1'b1, 1'b0, vals[i], 1'b1);
        for (int k = 1; k <= 8; k++) begin
            tick(1'b0, 1'b1, '0, 1'b1);
            if (k >= 2) begin
                n_tests++;
                if (dout !== pops[k-2]) begin
                    n_fail++;
                    $display("FAIL lifo_order pop%0d: got %0d want %0d", k, dout, pops[k-2]);
                end
            end
            if (k == 7) begin
                n_tests++;
                if (empty !== 1'b1) begin n_fail++; $display("FAIL lifo_empty_after_7: got %b want 1", empty); end
            end
        end
        tick(1'b0, 1'b0, '0, 1'b1);
    endtask

    task automatic test_full_boundary();
        tick(1'b0, 1'b0, '0, 1'b0);
        for (int i = 1; i <= 8; i++) tick(1'b1, 1'b0, WIDTH'(i), 1'b1);
        n_tests++;
        if (full !== 1'b1 || empty !== 1'b0) begin
            n_fail++;
            $display("FAIL full_after_8: got full=%b empty=%b want 1 0", full, empty);
        end
        tick(1'b1, 1'b0, 8'd99, 1'b1);
        n_tests++;
        if (full !== 1'b1) begin n_fail++; $display("FAIL full_after_9th: got %b want 1", full); end
`ifdef LIFO_ERR_FLAGS_EN
        n_tests++;
        if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", ovf); end
`endif
        for (int k = 1; k <= 9; k++) begin
            tick(1'b0, 1'b1, '0, 1'b1);
            if (k == 1) begin
                n_tests++;
                if (full !== 1'b0) begin n_fail++; $display("FAIL full_clear_after_pop: got %b want 0", full); end
            end else begin
                n_tests++;
                if (dout !== WIDTH'(10 - k)) begin
                    n_fail++;
                    $display("FAIL full_pop%0d: got %0d want %0d", k, dout, 10 - k);
                end
            end
        end
        tick(1'b0, 1'b0, '0, 1'b1);
        n_tests++;
        if (dout !== 8'd1 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL full_drained: got out=%0d empty=%b want 1 1", dout, empty);
        end
    endtask

    task automatic test_empty_pop();
        tick(1'b0, 1'b0, '0, 1'b0);
        tick(1'b1, 1'b0, 8'd33, 1'b1);
        tick(1'b0, 1'b1, '0, 1'b1);
        tick(1'b0, 1'b0, '0, 1'b1);
        n_tests++;
        if (dout !== 8'd33) begin n_fail++; $display("FAIL empty_pop_setup: got %0d want 33", dout); end
        for (int k = 0; k < 2; k++) begin
            tick(1'b0, 1'b1, '0, 1'b1);
            n_tests++;
            if (dout !== 8'd33 || empty !== 1'b1) begin
                n_fail++;
                $display("FAIL empty_pop_hold%0d: got out=%0d empty=%b want 33 1", k, dout, empty);
            end
        end
`ifdef LIFO_ERR_FLAGS_EN
        n_tests++;
        if (udf !== 1'b1) begin n_fail++; $display("FAIL udf_set: got %b want 1", udf); end
`endif
    endtask

    task automatic test_simultaneous();
        tick(1'b0, 1'b0, '0, 1'b0);
        tick(1'b1, 1'b0, 8'd5, 1'b1);
        tick(1'b1, 1'b0, 8'd6, 1'b1);
        tick(1'b1, 1'b1, 8'd77, 1'b1);
        n_tests++;
        if (empty !== 1'b0 || full !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_count1: got empty=%b full=%b want 0 0", empty, full);
        end
        tick(1'b0, 1'b1, '0, 1'b1);
        n_tests++;
        if (dout !== 8'd6) begin n_fail++; $display("FAIL simul_pop6: got %0d want 6", dout); end
        n_tests++;
        if (empty !== 1'b1) begin n_fail++; $display("FAIL simul_empty: got %b want 1", empty); end
        tick(1'b0, 1'b0, '0, 1'b1);
        n_tests++;
        if (dout !== 8'd5) begin n_fail++; $display("FAIL simul_pop5: got %0d want 5", dout); end
    endtask

    task automatic test_mid_reset();
        tick(1'b0, 1'b0, '0, 1'b0);
        tick(1'b1, 1'b0, 8'd10, 1'b1);
        tick(1'b1, 1'b0, 8'd20, 1'b1);
        tick(1'b1, 1'b0, 8'd30, 1'b1);
        tick(1'b0, 1'b1, '0, 1'b1);
        tick(1'b0, 1'b1, '0, 1'b0);
        n_tests++;
        if (empty !== 1'b1 || dout !== 8'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got empty=%b out=%0d want 1 0", empty, dout);
        end
        tick(1'b0, 1'b0, '0, 1'b1);
        n_tests++;
        if (dout !== 8'd0) begin n_fail++; $display("FAIL mid_reset_discard: got %0d want 0", dout); end
        tick(1'b1, 1'b0, 8'd42, 1'b1);
        tick(1'b0, 1'b1, '0, 1'b1);
        n_tests++;
        if (dout !== 8'd0) begin n_fail++; $display("FAIL mid_reset_latency: got %0d want 0", dout); end
        tick(1'b0, 1'b0, '0, 1'b1);
        n_tests++;
        if (dout !== 8'd42) begin n_fail++; $display("FAIL mid_reset_pop42: got %0d want 42", dout); end
    endtask

    task automatic test_random();
        logic w, r, rs;
        tick(1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 600; i++) begin
            // Phase-dependent bias so the stack repeatedly fills and drains.
            if ((i / 60) % 2 == 0) begin
                w = ($urandom_range(0, 9) < 7);
                r = ($urandom_range(0, 9) < 3);
            end else begin
                w = ($urandom_range(0, 9) < 3);
                r = ($urandom_range(0, 9) < 7);
            end
            rs = ($urandom_range(0, 79) != 0);
            tick(w, r, WIDTH'($urandom_range(0, 255)), rs);
            n_tests++;
            if (dout !== exp_out || empty !== (stk.size() == 0) || full !== (stk.size() == DEPTH)) begin
                n_fail++;
                $display("FAIL random cyc%0d: got out=%0d empty=%b full=%b want out=%0d empty=%b full=%b",
                         i, dout, empty, full, exp_out, (stk.size() == 0), (stk.size() == DEPTH));
            end
`ifdef LIFO_ERR_FLAGS_EN
            n_tests++;
            if (ovf !== exp_ovf || udf !== exp_udf) begin
                n_fail++;
                $display("FAIL random_flags cyc%0d: got ovf=%b udf=%b want %b %b", i, ovf, udf, exp_ovf, exp_udf);
            end
`endif
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst     = 1'b0;
        wn      = 1'b0;
        rn      = 1'b0;
        din     = '0;
        exp_out = '0;
        exp_ovf = 1'b0;
        exp_udf = 1'b0;
        test_reset();
        test_lifo_order();
        test_full_boundary();
        test_empty_pop();
        test_simultaneous();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
